// File: rtl/dcache_pkg.sv
// Shared types and width helpers for the N-way data cache controller.
package dcache_pkg;

   typedef enum logic [1:0] {
      CHECK      = 2'd0,
      WRITE_DONE = 2'd1,
      WRITEBACK  = 2'd2,
      FILL       = 2'd3
   } state_t;

   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 32'd1) ? $clog2(n) : 32'd1;
   endfunction

   // Index of the lowest set bit; associativity never exceeds eight ways.
   function automatic logic [2:0] lowest_set(input logic [7:0] v);
      logic [2:0] idx;
      idx = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         idx = v[i] ? 3'(i) : idx;
      end
      return idx;
   endfunction

endpackage

// File: rtl/dcache_plru_tree.sv
// Tree pseudo-LRU state per set: victim lookup and access update.
module dcache_plru_tree
   import dcache_pkg::*;
#(
   parameter int unsigned WAYS = 32'd4,
   parameter int unsigned SETS = 32'd16
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic [idx_width(SETS)-1:0]      set_index,
   input  logic                            access_en,
   input  logic [idx_width(WAYS)-1:0]      access_way,
   output logic [idx_width(WAYS)-1:0]      victim
);

   localparam int unsigned WAY_W  = idx_width(WAYS);
   localparam int unsigned LEVELS = $clog2(WAYS);
   localparam int unsigned NODES  = WAYS - 32'd1;

   // Node n has children 2n+1 (lower ways) and 2n+2; a 0 bit steers the victim low.
   logic [NODES-1:0] tree_r [SETS];
   logic [NODES-1:0] cur_s;
   logic [NODES-1:0] upd_s;
   logic [WAY_W-1:0] victim_s;

   assign cur_s  = tree_r[set_index];
   assign victim = victim_s;

   // walk the tree for the victim and build the post-access bit pattern
   always_comb begin
      int unsigned node;
      victim_s = '0;
      upd_s    = cur_s;
      node     = 32'd0;
      for (int l = 0; l < int'(LEVELS); l++) begin
         victim_s[LEVELS-32'd1-32'(l)] = cur_s[node];
         node = (32'd2 * node) + 32'd1 + {31'd0, cur_s[node]};
      end
      node = 32'd0;
      for (int l = 0; l < int'(LEVELS); l++) begin
         upd_s[node] = ~access_way[LEVELS-32'd1-32'(l)];
         node = (32'd2 * node) + 32'd1 + {31'd0, access_way[LEVELS-32'd1-32'(l)]};
      end
   end

   // per-set tree storage
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int s = 0; s < int'(SETS); s++) begin
            tree_r[s] <= '0;
         end
      end else if (access_en) begin
         tree_r[set_index] <= upd_s;
      end
   end

endmodule

// File: rtl/dcache_ctrl_nway.sv
// N-way write-back data cache controller with tree-PLRU replacement.
// Optional build macro DCACHE_INVALID_FIRST_EN: prefer an invalid way as victim.
module dcache_ctrl_nway
   import dcache_pkg::*;
#(
   parameter int unsigned WAYS       = 32'd4,
   parameter int unsigned SETS       = 32'd16,
   parameter int unsigned LINE_BYTES = 32'd32
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         mem_read,
   input  logic                         mem_write,
   input  logic [LINE_BYTES-1:0]        mem_byte_enable,
   input  logic [idx_width(SETS)-1:0]   set_index,
   input  logic [WAYS-1:0]              hit,
   input  logic [WAYS-1:0]              valid_out,
   input  logic [WAYS-1:0]              dirty_out,
   input  logic                         pmem_resp,
   output logic                         mem_resp,
   output logic                         pmem_read,
   output logic                         pmem_write,
   output logic [idx_width(WAYS)-1:0]   victim_way,
   output logic [WAYS-1:0]              data_we,
   output logic [WAYS-1:0]              load_tag,
   output logic [WAYS-1:0]              load_valid,
   output logic [WAYS-1:0]              load_dirty,
   output logic                         set_valid,
   output logic                         set_dirty,
   output logic [LINE_BYTES-1:0]        data_byte_en,
   output logic                         data_src_sel,
   output logic                         hit_multi_err
);

   localparam int unsigned    WAY_W   = idx_width(WAYS);
   localparam logic [WAYS-1:0] WAY_ONE = {{(WAYS-1){1'b0}}, 1'b1};

   state_t           state_r;
   state_t           state_s;
   logic [WAY_W-1:0] victim_r;
   logic [WAY_W-1:0] plru_victim_s;
   logic [WAY_W-1:0] choose_s;
   logic [WAY_W-1:0] hit_way_s;
   logic             req_s;
   logic             hit_any_s;
   logic             multi_s;
   logic             miss_s;
   logic             access_en_s;

   assign req_s       = mem_read | mem_write;
   assign hit_any_s   = |hit;
   assign multi_s     = |(hit & (hit - WAY_ONE));
   assign hit_way_s   = WAY_W'(lowest_set(8'(hit)));
   assign miss_s      = (state_r == CHECK) & req_s & ~hit_any_s;
   assign access_en_s = (state_r == CHECK) & req_s & hit_any_s;

   dcache_plru_tree #(
      .WAYS (WAYS),
      .SETS (SETS)
   ) u_plru (
      .clk        (clk),
      .rst_n      (rst_n),
      .set_index  (set_index),
      .access_en  (access_en_s),
      .access_way (hit_way_s),
      .victim     (plru_victim_s)
   );

`ifdef DCACHE_INVALID_FIRST_EN
   // an empty way is always a cheaper victim than any tree choice
   always_comb begin
      if (|(~valid_out)) begin
         choose_s = WAY_W'(lowest_set(8'(~valid_out)));
      end else begin
         choose_s = plru_victim_s;
      end
   end
`else
   assign choose_s = plru_victim_s;
`endif

   // The victim is only meaningful while a line transfer is in flight.
   assign victim_way = ((state_r == WRITEBACK) || (state_r == FILL)) ? victim_r : '0;

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= CHECK;
      end else begin
         state_r <= state_s;
      end
   end

   // victim latch, frozen from miss detection until the fill completes
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         victim_r <= '0;
      end else if (miss_s) begin
         victim_r <= choose_s;
      end
   end

   // next-state and strobe decode
   always_comb begin
      state_s       = state_r;
      mem_resp      = 1'b0;
      pmem_read     = 1'b0;
      pmem_write    = 1'b0;
      data_we       = '0;
      load_tag      = '0;
      load_valid    = '0;
      load_dirty    = '0;
      set_valid     = 1'b0;
      set_dirty     = 1'b0;
      data_byte_en  = '0;
      data_src_sel  = 1'b0;
      hit_multi_err = 1'b0;
      case (state_r)
         CHECK: begin
            if (req_s) begin
               hit_multi_err = multi_s;
               if (hit_any_s) begin
                  if (mem_write) begin
                     data_we      = WAY_ONE << hit_way_s;
                     data_byte_en = mem_byte_enable;
                     load_dirty   = WAY_ONE << hit_way_s;
                     set_dirty    = 1'b1;
                     state_s      = WRITE_DONE;
                  end else begin
                     mem_resp = 1'b1;
                     state_s  = CHECK;
                  end
               end else if (valid_out[choose_s] & dirty_out[choose_s]) begin
                  state_s = WRITEBACK;
               end else begin
                  state_s = FILL;
               end
            end else begin
               state_s = CHECK;
            end
         end
         WRITE_DONE: begin
            mem_resp = 1'b1;
            state_s  = CHECK;
         end
         WRITEBACK: begin
            pmem_write = 1'b1;
            if (pmem_resp) begin
               load_dirty = WAY_ONE << victim_r;
               set_dirty  = 1'b0;
               state_s    = FILL;
            end else begin
               state_s = WRITEBACK;
            end
         end
         FILL: begin
            pmem_read    = 1'b1;
            data_src_sel = 1'b1;
            data_we      = WAY_ONE << victim_r;
            data_byte_en = '1;
            if (pmem_resp) begin
               load_tag   = WAY_ONE << victim_r;
               load_valid = WAY_ONE << victim_r;
               set_valid  = 1'b1;
               state_s    = CHECK;
            end else begin
               state_s = FILL;
            end
         end
         default: begin
            state_s = CHECK;
         end
      endcase
   end

endmodule

// File: tb/tb_dcache_ctrl_nway.sv
// Self-checking bench for dcache_ctrl_nway against a range-halving tree-PLRU model.
module tb_dcache_ctrl_nway;

   localparam int WAYS = 4;
   localparam int SETS = 16;
   localparam int LB   = 32;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          mem_read, mem_write, pmem_resp;
   logic [LB-1:0] mem_byte_enable;
   logic [3:0]    set_index;
   logic [3:0]    hit, valid_out, dirty_out;
   logic          mem_resp, pmem_read, pmem_write, set_valid, set_dirty, data_src_sel, hit_multi_err;
   logic [1:0]    victim_way;
   logic [3:0]    data_we, load_tag, load_valid, load_dirty;
   logic [LB-1:0] data_byte_en;

   int compared   = 0;
   int mismatched = 0;

   // Model: for every subtree (set, lo, size) remember whether its lower half was used last.
   bit left_recent [int];

   dcache_ctrl_nway #(.WAYS(WAYS), .SETS(SETS), .LINE_BYTES(LB)) dut (
      .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
      .mem_byte_enable(mem_byte_enable), .set_index(set_index), .hit(hit),
      .valid_out(valid_out), .dirty_out(dirty_out), .pmem_resp(pmem_resp),
      .mem_resp(mem_resp), .pmem_read(pmem_read), .pmem_write(pmem_write),
      .victim_way(victim_way), .data_we(data_we), .load_tag(load_tag),
      .load_valid(load_valid), .load_dirty(load_dirty), .set_valid(set_valid),
      .set_dirty(set_dirty), .data_byte_en(data_byte_en), .data_src_sel(data_src_sel),
      .hit_multi_err(hit_multi_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] all_out();
      return {7'd0, mem_resp, pmem_read, pmem_write, data_we, load_tag, load_valid, load_dirty,
              set_valid, set_dirty, data_byte_en, data_src_sel, hit_multi_err, victim_way};
   endfunction

   function automatic int key(input int s, input int lo, input int size);
      return s * 256 + lo * 16 + size;
   endfunction

   function automatic int m_victim(input int s, input logic [3:0] valid);
      int lo, size, half;
`ifdef DCACHE_INVALID_FIRST_EN
      for (int i = 0; i < WAYS; i++) if (!valid[i]) return i;
`endif
      lo = 0; size = WAYS;
      while (size > 1) begin
         half = size / 2;
         if (left_recent.exists(key(s, lo, size)) && left_recent[key(s, lo, size)]) lo = lo + half;
         size = half;
      end
      return lo;
   endfunction

   function automatic void m_access(input int s, input int w);
      int lo, size, half;
      lo = 0; size = WAYS;
      while (size > 1) begin
         half = size / 2;
         if (w < lo + half) left_recent[key(s, lo, size)] = 1'b1;
         else begin
            left_recent[key(s, lo, size)] = 1'b0;
            lo = lo + half;
         end
         size = half;
      end
   endfunction

   function automatic int lowest(input logic [3:0] v);
      for (int i = 0; i < WAYS; i++) if (v[i]) return i;
      return 0;
   endfunction

   // Entered just after a rising edge; presents a hit and follows it to completion.
   task automatic hit_phase(input int s, input bit wr, input logic [31:0] mask, input logic [3:0] hv);
      int w;
      w = lowest(hv);
      mem_read = !wr; mem_write = wr; set_index = 4'(s); mem_byte_enable = wr ? mask : 32'd0;
      hit = hv; valid_out = 4'hF; dirty_out = 4'h0;
      @(negedge clk);
      chk("hit_multi_err", {63'd0, hit_multi_err}, {63'd0, ($countones(hv) > 1)});
      if (wr) begin
         chk("wr_data_we", {60'd0, data_we}, {60'd0, 4'b0001 << w});
         chk("wr_byte_en", {32'd0, data_byte_en}, {32'd0, mask});
         chk("wr_load_dirty_set", {59'd0, load_dirty, set_dirty}, {59'd0, 4'b0001 << w, 1'b1});
         chk("wr_resp_c1", {63'd0, mem_resp}, 64'd0);
         @(posedge clk); #1;
         @(negedge clk);
         chk("wr_resp_c2", {63'd0, mem_resp}, 64'd1);
         chk("wr_done_quiet", {52'd0, data_we, load_dirty, load_tag}, 64'd0);
      end else begin
         chk("rd_resp", {63'd0, mem_resp}, 64'd1);
         chk("rd_no_strobe", {60'd0, data_we}, 64'd0);
      end
      m_access(s, w);
      @(posedge clk); #1;
      mem_read = 1'b0; mem_write = 1'b0; hit = 4'h0;
      @(negedge clk);
      chk("idle_after_hit", all_out(), 64'd0);
   endtask

   // Entered just after a rising edge; runs a miss through writeback/fill.
   task automatic miss(input int s, input bit wr, input logic [31:0] mask, input logic [3:0] vv,
                       input logic [3:0] dv, input int wb_delay, input int fill_delay, input bit drop);
      int  v;
      bit  wb;
      v  = m_victim(s, vv);
      wb = vv[v] & dv[v];
      mem_read = !wr; mem_write = wr; set_index = 4'(s); mem_byte_enable = wr ? mask : 32'd0;
      hit = 4'h0; valid_out = vv; dirty_out = dv; pmem_resp = 1'b0;
      @(negedge clk);
      chk("miss_quiet", {61'd0, mem_resp, pmem_read, pmem_write}, 64'd0);
      @(posedge clk); #1;
      if (drop) begin mem_read = 1'b0; mem_write = 1'b0; end
      valid_out = 4'($urandom); dirty_out = 4'($urandom); hit = 4'($urandom);
      if (wb) begin
         for (int i = 0; i < wb_delay; i++) begin
            @(negedge clk);
            chk("wb_pmem", {62'd0, pmem_write, pmem_read}, {62'd0, 2'b10});
            chk("wb_victim", {62'd0, victim_way}, 64'(v));
            @(posedge clk); #1;
         end
         pmem_resp = 1'b1;
         @(negedge clk);
         chk("wb_clean", {59'd0, load_dirty, set_dirty}, {59'd0, 4'b0001 << v, 1'b0});
         @(posedge clk); #1;
         pmem_resp = 1'b0;
      end
      for (int i = 0; i < fill_delay; i++) begin
         @(negedge clk);
         chk("fill_pmem", {62'd0, pmem_write, pmem_read}, {62'd0, 2'b01});
         chk("fill_strobes", {56'd0, data_we, load_tag}, {56'd0, 4'b0001 << v, 4'd0});
         chk("fill_src_be", {31'd0, data_src_sel, data_byte_en}, {31'd0, 1'b1, 32'hFFFF_FFFF});
         chk("fill_victim", {62'd0, victim_way}, 64'(v));
         @(posedge clk); #1;
      end
      pmem_resp = 1'b1;
      @(negedge clk);
      chk("fill_load", {55'd0, load_tag, load_valid, set_valid}, {55'd0, 4'b0001 << v, 4'b0001 << v, 1'b1});
      chk("fill_resp_quiet", {63'd0, mem_resp}, 64'd0);
      @(posedge clk); #1;
      pmem_resp = 1'b0;
      if (drop) begin
         hit = 4'h0;
         @(negedge clk);
         chk("drop_idle", all_out(), 64'd0);
      end else begin
         hit_phase(s, wr, mask, 4'b0001 << v);
      end
   endtask

   initial begin
      rst_n = 1'b0; mem_read = 1'b0; mem_write = 1'b0; pmem_resp = 1'b0;
      mem_byte_enable = '0; set_index = '0; hit = '0; valid_out = '0; dirty_out = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_outputs", all_out(), 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      // read hit on way 2, then a clean miss shows the tree now points away from way 2
      hit_phase(5, 1'b0, 32'd0, 4'b0100);
      @(posedge clk); #1;
      miss(5, 1'b0, 32'd0, 4'hF, 4'h0, 0, 1, 1'b0);

      // write hit on way 1 with a low-nibble mask
      @(posedge clk); #1;
      hit_phase(3, 1'b1, 32'h0000_000F, 4'b0010);

      // steer set 7 to victim 3, then a dirty miss with a five-cycle writeback
      @(posedge clk); #1;
      hit_phase(7, 1'b0, 32'd0, 4'b0100);
      @(posedge clk); #1;
      hit_phase(7, 1'b0, 32'd0, 4'b0001);
      @(posedge clk); #1;
      miss(7, 1'b0, 32'd0, 4'hF, 4'h8, 4, 2, 1'b0);

      // multiple hit bits resolve to the lowest way
      @(posedge clk); #1;
      hit_phase(9, 1'b1, 32'hA5A5_0000, 4'b0110);
      @(posedge clk); #1;
      hit_phase(9, 1'b0, 32'd0, 4'b1100);

      // request withdrawn mid-transfer
      @(posedge clk); #1;
      miss(2, 1'b1, 32'h1234_5678, 4'hF, 4'hF, 1, 1, 1'b1);

`ifdef DCACHE_INVALID_FIRST_EN
      @(posedge clk); #1;
      miss(11, 1'b0, 32'd0, 4'b1011, 4'hF, 0, 1, 1'b0);
`endif

      // reset during fill drops pmem_read without waiting for a clock edge
      @(posedge clk); #1;
      mem_read = 1'b1; set_index = 4'd4; hit = 4'h0; valid_out = 4'hF; dirty_out = 4'h0;
      @(posedge clk); #1;
      @(negedge clk);
      chk("rst_fill_active", {63'd0, pmem_read}, 64'd1);
      #2 rst_n = 1'b0;
      #1 chk("rst_async_drop", all_out(), 64'd0);
      left_recent.delete();
      mem_read = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_release_idle", all_out(), 64'd0);
      @(posedge clk); #1;
      hit_phase(4, 1'b0, 32'd0, 4'b1000);

      // randomized traffic
      for (int n = 0; n < 40; n++) begin
         int          s, r;
         bit          wr;
         logic [31:0] mask;
         logic [3:0]  hv;
         s    = int'($urandom_range(0, SETS - 1));
         wr   = 1'($urandom_range(0, 1));
         mask = $urandom;
         r    = int'($urandom_range(0, 3));
         @(posedge clk); #1;
         if (r < 2) begin
            hit_phase(s, wr, mask, 4'b0001 << $urandom_range(0, 3));
         end else if (r == 2) begin
            hv = 4'($urandom_range(3, 15));
            while ($countones(hv) < 2) hv = 4'($urandom_range(3, 15));
            hit_phase(s, wr, mask, hv);
         end else begin
            miss(s, wr, mask, 4'($urandom), 4'($urandom), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 3)), ($urandom_range(0, 5) == 0));
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
